wb_queue: RTL and testbench
===========================

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 32, write-data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register-address width.
REQ-003 SHALL have parameter DEPTH, default 4, number of queue entries; legal values are powers of two, 2..16.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port rdy  input  1  global ready; low freezes the block.
REQ-007 SHALL have port flush  input  1  discards all queued entries.
REQ-008 SHALL have port ma_valid  input  1  an MA result is offered.
REQ-009 SHALL have port ma_ready  output  1  the queue accepts an offer this cycle.
REQ-010 SHALL have ports ma_we (input, 1), ma_waddr (input, ADDR_W) and ma_wdata (input, DATA_W), the offered write.
REQ-011 SHALL have port rf_ready  input  1  the register file consumes the head entry this cycle.
REQ-012 SHALL have ports wb_we (output, 1), wb_waddr (output, ADDR_W) and wb_wdata (output, DATA_W), the register-file write port.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-014 SHALL have ports fwd_raddr (input, ADDR_W), fwd_hit (output, 1) and fwd_data (output, DATA_W), the forwarding lookup (see Configuration).

Function
REQ-015 SHALL be a circular FIFO of DEPTH entries {waddr, wdata} with head/tail pointers wrapping modulo DEPTH.
REQ-016 SHALL drive ma_ready = rdy & ~flush & (count < DEPTH); there is no combinational dependence on rf_ready.
REQ-017 SHALL push on a clock edge when rdy & ~flush & ma_valid & ma_ready & ma_we & (ma_waddr != 0).
REQ-018 SHALL treat an accepted offer with ma_we=0 or ma_waddr=0 as consumed and shall not store it.
REQ-019 SHALL drive the wb_* outputs from the head entry only: wb_we = rdy & (count != 0), with wb_waddr/wb_wdata taken from the head entry; when empty, wb_waddr=0 and wb_wdata=0.
REQ-020 SHALL pop the head on a clock edge when rdy & ~flush & (count != 0) & rf_ready.
REQ-021 SHALL allow a simultaneous push and pop in one cycle, leaving count unchanged; at count=DEPTH no push occurs even if a pop occurs.
REQ-022 SHALL give a minimum latency of 1 cycle, from push edge to wb_we high.
REQ-023 SHALL, on flush with rdy high, set count=0 and head=tail=0 at the next edge; flush overrides a simultaneous push and pop.
REQ-024 SHALL, while rdy is low, hold all state and drive ma_ready=0 and wb_we=0.
REQ-025 SHALL keep count equal to (tail - head) modulo 2·DEPTH at all times.

Reset
REQ-026 SHALL, on an edge with rst high, set head=0, tail=0 and count=0 regardless of rdy and flush.
REQ-027 SHALL, from that edge onward, drive wb_we=0, wb_waddr=0, wb_wdata=0, fwd_hit=0 and fwd_data=0.
REQ-028 SHALL let a reset asserted mid-operation discard all queued entries; no wb_we pulse follows.
REQ-029 SHALL NOT reset entry storage contents; outputs are masked by count instead.

Configuration
REQ-030 SHALL, with macro WB_QUEUE_FWD_EN defined, set fwd_hit=1 when any occupied entry has waddr == fwd_raddr and fwd_raddr != 0, combinationally.
REQ-031 SHALL, in that case, drive fwd_data from the youngest matching occupied entry, otherwise 0.
REQ-032 SHALL, with WB_QUEUE_FWD_EN undefined, tie fwd_hit=0 and fwd_data=0, with no compare logic synthesized; ports remain present.

Verification
REQ-033 SHALL cover: rst held 2 cycles, then ma_valid=1, ma_we=1, ma_waddr=3, ma_wdata=32'hDEADBEEF, rf_ready=1 -> next cycle wb_we=1, wb_waddr=3, wb_wdata=32'hDEADBEEF, count=1.
REQ-034 SHALL cover: rf_ready=0 with 5 pushes (addr 1..5), DEPTH=4 -> count=4, ma_ready=0, 5th offer held; rf_ready=1 -> outputs drain in order addr 1,2,3,4, then 5.
REQ-035 SHALL cover: push ma_waddr=0 and a push with ma_we=0 -> count stays 0, wb_we stays 0.
REQ-036 SHALL cover: 3 entries queued, flush=1 together with ma_valid=1 -> next cycle count=0, wb_we=0.
REQ-037 SHALL cover: 2 entries queued, rdy=0 for 3 cycles with rf_ready=1 -> count stays 2, wb_we=0 and ma_ready=0 throughout.
REQ-038 SHALL cover, with WB_QUEUE_FWD_EN: entries {7:0x11, 7:0x22}, fwd_raddr=7 -> fwd_hit=1, fwd_data=0x22; fwd_raddr=0 -> fwd_hit=0.

Source files
------------

// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : wb_queue
// Purpose  : Write-back queue between the MA stage and the register file.
//            A circular FIFO of DEPTH {waddr, wdata} entries. MA offers are
//            accepted while the queue has room. Offers that write nothing
//            (ma_we=0 or waddr=0) are consumed without being stored. The head
//            entry is presented on the wb_* port and is popped when rf_ready
//            is high. rdy low freezes the block. flush empties it.
// Ports    : clk, rst              clock, synchronous active-high reset
//            rdy, flush            global ready / discard all entries
//            ma_valid/ma_ready     MA offer handshake
//            ma_we/ma_waddr/ma_wdata  offered write
//            rf_ready              register file consumes the head entry
//            wb_we/wb_waddr/wb_wdata  register-file write port
//            count                 number of occupied entries
//            fwd_raddr/fwd_hit/fwd_data  forwarding lookup
// Macro    : WB_QUEUE_FWD_EN  enables the forwarding compare logic. When it
//            is undefined, fwd_hit and fwd_data are tied to 0.
// Revision : 1.0  initial release
// ============================================================================
module wb_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic                       ma_valid,
  output logic                       ma_ready,
  input  logic                       ma_we,
  input  logic [ADDR_W-1:0]          ma_waddr,
  input  logic [DATA_W-1:0]          ma_wdata,
  input  logic                       rf_ready,
  output logic                       wb_we,
  output logic [ADDR_W-1:0]          wb_waddr,
  output logic [DATA_W-1:0]          wb_wdata,
  output logic [$clog2(DEPTH):0]     count,
  input  logic [ADDR_W-1:0]          fwd_raddr,
  output logic                       fwd_hit,
  output logic [DATA_W-1:0]          fwd_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

  // The pointers carry one extra wrap bit. This lets full and empty be told
  // apart, and makes occupancy a plain subtraction modulo 2*DEPTH.
  logic [CNT_W-1:0]  r_head;
  logic [CNT_W-1:0]  r_tail;
  logic [ADDR_W-1:0] r_addr_mem [DEPTH];
  logic [DATA_W-1:0] r_data_mem [DEPTH];

  logic [CNT_W-1:0]  w_count;
  logic [PTR_W-1:0]  w_head_idx;
  logic [PTR_W-1:0]  w_tail_idx;
  logic              w_nonempty;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;

  assign w_count    = r_tail - r_head;
  assign w_head_idx = r_head[PTR_W-1:0];
  assign w_tail_idx = r_tail[PTR_W-1:0];
  assign w_nonempty = (w_count != '0);

  assign ma_ready = rdy & ~flush & (w_count < c_DEPTH);
  assign w_accept = rdy & ~flush & ma_valid & ma_ready;
  // Writes to register 0, and offers that do not write, leave the queue untouched.
  assign w_push   = w_accept & ma_we & (ma_waddr != '0);
  assign w_pop    = rdy & ~flush & w_nonempty & rf_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (rdy) begin
      if (flush) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_push) r_tail <= r_tail + CNT_W'(1);
        if (w_pop)  r_head <= r_head + CNT_W'(1);
      end
    end
  end

  // Storage is not reset. Stale contents are hidden by the occupancy count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr_mem[w_tail_idx] <= ma_waddr;
      r_data_mem[w_tail_idx] <= ma_wdata;
    end
  end

  assign count    = w_count;
  assign wb_we    = rdy & w_nonempty;
  assign wb_waddr = w_nonempty ? r_addr_mem[w_head_idx] : '0;
  assign wb_wdata = w_nonempty ? r_data_mem[w_head_idx] : '0;

`ifdef WB_QUEUE_FWD_EN
  logic [PTR_W-1:0] w_fwd_idx;

  // Scan from oldest to youngest, so the youngest matching entry wins.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_data  = '0;
    w_fwd_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_fwd_idx = w_head_idx + PTR_W'(i);
      if ((CNT_W'(i) < w_count) && (fwd_raddr != '0) &&
          (r_addr_mem[w_fwd_idx] == fwd_raddr)) begin
        fwd_hit  = 1'b1;
        fwd_data = r_data_mem[w_fwd_idx];
      end
    end
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^fwd_raddr;
  assign fwd_hit      = 1'b0;
  assign fwd_data     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_queue
// Purpose  : Directed self-checking bench for wb_queue (DEPTH=4, DATA_W=32).
//            Each step drives inputs, advances one clock, and then compares
//            the outputs against hand-computed values.
// Macro    : WB_QUEUE_FWD_EN selects the expected forwarding results.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_queue;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst, rdy, flush, ma_valid, ma_we, rf_ready;
  logic              ma_ready, wb_we, fwd_hit;
  logic [ADDR_W-1:0] ma_waddr, wb_waddr, fwd_raddr;
  logic [DATA_W-1:0] ma_wdata, wb_wdata, fwd_data;
  logic [2:0]        count;

  int n_checks = 0;
  int n_errors = 0;

  wb_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .ma_valid(ma_valid), .ma_ready(ma_ready), .ma_we(ma_we),
    .ma_waddr(ma_waddr), .ma_wdata(ma_wdata), .rf_ready(rf_ready),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .count(count), .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit),
    .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ma_valid = 1'b1; ma_we = 1'b1; ma_waddr = a; ma_wdata = d;
    step();
    ma_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; ma_valid = 1'b0; ma_we = 1'b0;
    ma_waddr = '0; ma_wdata = '0; rf_ready = 1'b0; fwd_raddr = '0;

    // Reset held for 2 cycles
    step(); step();
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_wb_we", 64'(wb_we), 64'(0));
    chk("rst_waddr", 64'(wb_waddr), 64'(0));
    chk("rst_wdata", 64'(wb_wdata), 64'(0));
    chk("rst_fwd_hit", 64'(fwd_hit), 64'(0));
    chk("rst_fwd_data", 64'(fwd_data), 64'(0));
    rst = 1'b0;

    // Single push: 1-cycle latency to wb_we
    ma_valid = 1'b1; ma_we = 1'b1; ma_waddr = 5'd3; ma_wdata = 32'hDEADBEEF;
    rf_ready = 1'b1;
    #1 chk("first_ma_ready", 64'(ma_ready), 64'(1));
    step();
    chk("first_wb_we", 64'(wb_we), 64'(1));
    chk("first_waddr", 64'(wb_waddr), 64'(3));
    chk("first_wdata", 64'(wb_wdata), 64'hDEADBEEF);
    chk("first_count", 64'(count), 64'(1));
    ma_valid = 1'b0;
    step();
    chk("first_pop_count", 64'(count), 64'(0));
    chk("first_pop_wb_we", 64'(wb_we), 64'(0));

    // Fill to DEPTH with rf_ready low. The 5th offer is held.
    rf_ready = 1'b0;
    for (int a = 1; a <= 4; a++) push(5'(a), 32'h100 + 32'(a));
    chk("full_count", 64'(count), 64'(4));
    ma_valid = 1'b1; ma_we = 1'b1; ma_waddr = 5'd5; ma_wdata = 32'h105;
    #1 chk("full_ma_ready", 64'(ma_ready), 64'(0));
    step();
    chk("full_hold_count", 64'(count), 64'(4));
    chk("full_head_addr", 64'(wb_waddr), 64'(1));
    rf_ready = 1'b1;
    step();                       // pop 1 only (queue full at edge)
    chk("drain1_count", 64'(count), 64'(3));
    chk("drain1_addr", 64'(wb_waddr), 64'(2));
    step();                       // push 5 and pop 2 together
    chk("drain2_count", 64'(count), 64'(3));
    chk("drain2_addr", 64'(wb_waddr), 64'(3));
    ma_valid = 1'b0;
    step();
    chk("drain3_addr", 64'(wb_waddr), 64'(4));
    chk("drain3_wdata", 64'(wb_wdata), 64'h104);
    step();
    chk("drain4_addr", 64'(wb_waddr), 64'(5));
    chk("drain4_wdata", 64'(wb_wdata), 64'h105);
    chk("drain4_count", 64'(count), 64'(1));
    step();
    chk("drained_count", 64'(count), 64'(0));
    chk("drained_wb_we", 64'(wb_we), 64'(0));
    chk("drained_waddr", 64'(wb_waddr), 64'(0));
    chk("drained_wdata", 64'(wb_wdata), 64'(0));

    // Offers that write nothing are not stored
    rf_ready = 1'b0;
    push(5'd0, 32'hAAAA);
    chk("zero_addr_count", 64'(count), 64'(0));
    chk("zero_addr_wb_we", 64'(wb_we), 64'(0));
    ma_valid = 1'b1; ma_we = 1'b0; ma_waddr = 5'd9; ma_wdata = 32'hBBBB;
    step();
    ma_valid = 1'b0;
    chk("no_we_count", 64'(count), 64'(0));
    chk("no_we_wb_we", 64'(wb_we), 64'(0));

    // Flush overrides a simultaneous push
    push(5'd10, 32'h10); push(5'd11, 32'h11); push(5'd12, 32'h12);
    chk("preflush_count", 64'(count), 64'(3));
    flush = 1'b1;
    ma_valid = 1'b1; ma_we = 1'b1; ma_waddr = 5'd13; ma_wdata = 32'h13;
    #1 chk("flush_ma_ready", 64'(ma_ready), 64'(0));
    step();
    flush = 1'b0; ma_valid = 1'b0;
    chk("flush_count", 64'(count), 64'(0));
    chk("flush_wb_we", 64'(wb_we), 64'(0));

    // rdy low freezes the block
    push(5'd20, 32'h20); push(5'd21, 32'h21);
    rdy = 1'b0; rf_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_count", 64'(count), 64'(2));
      chk("stall_wb_we", 64'(wb_we), 64'(0));
      chk("stall_ma_ready", 64'(ma_ready), 64'(0));
    end
    rf_ready = 1'b0; rdy = 1'b1;
    #1 chk("unstall_wb_we", 64'(wb_we), 64'(1));
    chk("unstall_addr", 64'(wb_waddr), 64'(20));

    // Forwarding lookup
    flush = 1'b1; step(); flush = 1'b0;
    push(5'd7, 32'h11); push(5'd7, 32'h22);
    fwd_raddr = 5'd7;
    #1;
`ifdef WB_QUEUE_FWD_EN
    chk("fwd7_hit", 64'(fwd_hit), 64'(1));
    chk("fwd7_data", 64'(fwd_data), 64'h22);
`else
    chk("fwd7_hit", 64'(fwd_hit), 64'(0));
    chk("fwd7_data", 64'(fwd_data), 64'(0));
`endif
    fwd_raddr = 5'd0;
    #1 chk("fwd0_hit", 64'(fwd_hit), 64'(0));
    chk("fwd0_data", 64'(fwd_data), 64'(0));
    fwd_raddr = 5'd5;
    #1 chk("fwd5_hit", 64'(fwd_hit), 64'(0));

    // Reset mid-operation discards entries
    chk("prereset_count", 64'(count), 64'(2));
    rst = 1'b1; rf_ready = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_count", 64'(count), 64'(0));
    chk("midrst_wb_we", 64'(wb_we), 64'(0));
    chk("midrst_fwd_hit", 64'(fwd_hit), 64'(0));
    step();
    chk("postrst_wb_we", 64'(wb_we), 64'(0));
    chk("postrst_count", 64'(count), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
